// File: rtl/xform_pkg.sv
// rtl/xform_pkg.sv - shared types and helpers for the character-transform line streamer
package xform_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_CAPT,
        ST_OUT,
        ST_EMPTY
    } xform_state_t;

    localparam logic [63:0] XFORM_BLANK = 64'd0;

    // Line-table entries are packed {len, start}; callers narrow the result to their widths.
    function automatic logic [63:0] entry_len(input logic [63:0] entry, input int addr_w);
        return entry >> addr_w;
    endfunction

    function automatic logic [63:0] entry_start(input logic [63:0] entry, input int addr_w);
        return entry & ((64'd1 << addr_w) - 64'd1);
    endfunction

endpackage

// File: rtl/xform_line_streamer_if.sv
// rtl/xform_line_streamer_if.sv - request, table, pair-memory and output stream bundle
interface xform_line_streamer_if #(
    parameter int CHAR_W = 8,
    parameter int ADDR_W = 8,
    parameter int LINE_W = 8,
    parameter int LEN_W  = 8
);
    logic                     req_valid;
    logic                     req_ready;
    logic [LINE_W-1:0]        req_line;
    logic                     abort;
    logic [LINE_W-1:0]        tbl_line;
    logic [LEN_W+ADDR_W-1:0]  tbl_entry;
    logic                     mem_rd;
    logic [ADDR_W-1:0]        mem_addr;
    logic [2*CHAR_W-1:0]      mem_dout;
    logic                     out_valid;
    logic                     out_ready;
    logic [CHAR_W-1:0]        out_lhs;
    logic [CHAR_W-1:0]        out_rhs;
    logic                     out_first;
    logic                     out_last;
    logic                     out_empty;
    logic                     busy;

    modport master (
        input  req_valid, req_line, abort, tbl_entry, mem_dout, out_ready,
        output req_ready, tbl_line, mem_rd, mem_addr, out_valid, out_lhs, out_rhs,
               out_first, out_last, out_empty, busy
    );

    modport slave (
        output req_valid, req_line, abort, tbl_entry, mem_dout, out_ready,
        input  req_ready, tbl_line, mem_rd, mem_addr, out_valid, out_lhs, out_rhs,
               out_first, out_last, out_empty, busy
    );
endinterface

// File: rtl/xform_line_streamer.sv
// rtl/xform_line_streamer.sv - looks up a line and streams its lhs/rhs character pairs
module xform_line_streamer
    import xform_pkg::*;
#(
    parameter int CHAR_W = 8,
    parameter int ADDR_W = 8,
    parameter int LINE_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    xform_line_streamer_if.master bus
);

    xform_state_t        r_state;
    logic [ADDR_W-1:0]   r_ptr;
    logic [LEN_W-1:0]    r_len;
    logic [LEN_W-1:0]    r_cnt;
    logic                r_mem_rd;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic                r_out_valid;
    logic [CHAR_W-1:0]   r_lhs;
    logic [CHAR_W-1:0]   r_rhs;
    logic                r_first;
    logic                r_last;
    logic                r_empty;

    logic [LEN_W-1:0]    w_req_len;
    logic [ADDR_W-1:0]   w_req_start;
    logic                w_accept;

    assign w_req_len   = LEN_W'(entry_len(64'(bus.tbl_entry), ADDR_W));
    assign w_req_start = ADDR_W'(entry_start(64'(bus.tbl_entry), ADDR_W));
    assign w_accept    = r_out_valid && bus.out_ready;

    assign bus.tbl_line  = bus.req_line;
    assign bus.req_ready = (r_state == ST_IDLE);
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.mem_rd    = r_mem_rd;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.out_valid = r_out_valid;
    assign bus.out_lhs   = r_lhs;
    assign bus.out_rhs   = r_rhs;
    assign bus.out_first = r_first;
    assign bus.out_last  = r_last;
    assign bus.out_empty = r_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_mem_rd    <= 1'b0;
            r_mem_addr  <= '0;
            r_out_valid <= 1'b0;
            {r_lhs, r_rhs} <= (2*CHAR_W)'(XFORM_BLANK);
            r_first     <= 1'b0;
            r_last      <= 1'b0;
            r_empty     <= 1'b0;
        end else if (r_state != ST_IDLE && bus.abort) begin
            // Abort wins over a same-cycle accept: the pending beat is dropped.
            r_state     <= ST_IDLE;
            r_mem_rd    <= 1'b0;
            r_out_valid <= 1'b0;
            {r_lhs, r_rhs} <= (2*CHAR_W)'(XFORM_BLANK);
            r_first     <= 1'b0;
            r_last      <= 1'b0;
            r_empty     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        r_ptr <= w_req_start;
                        r_len <= w_req_len;
                        r_cnt <= '0;
                        if (w_req_len == '0) begin
                            r_state     <= ST_EMPTY;
                            r_out_valid <= 1'b1;
                            {r_lhs, r_rhs} <= (2*CHAR_W)'(XFORM_BLANK);
                            r_first     <= 1'b1;
                            r_last      <= 1'b1;
                            r_empty     <= 1'b1;
                        end else begin
                            r_state    <= ST_READ;
                            r_mem_rd   <= 1'b1;
                            r_mem_addr <= w_req_start;
                        end
                    end
                end
                ST_READ: begin
                    r_mem_rd <= 1'b0;
                    r_state  <= ST_CAPT;
                end
                ST_CAPT: begin
                    {r_lhs, r_rhs} <= bus.mem_dout;
                    r_out_valid    <= 1'b1;
                    r_first        <= (r_cnt == '0);
                    r_last         <= (r_cnt == r_len - LEN_W'(1));
                    r_state        <= ST_OUT;
                end
                ST_OUT: begin
                    if (w_accept) begin
                        r_out_valid <= 1'b0;
                        r_first     <= 1'b0;
                        r_last      <= 1'b0;
                        if (r_last) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_ptr      <= r_ptr + ADDR_W'(1);
                            r_cnt      <= r_cnt + LEN_W'(1);
                            r_mem_rd   <= 1'b1;
                            r_mem_addr <= r_ptr + ADDR_W'(1);
                            r_state    <= ST_READ;
                        end
                    end
                end
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_out_valid <= 1'b0;
                        r_first     <= 1'b0;
                        r_last      <= 1'b0;
                        r_empty     <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xform_line_streamer.sv
// tb/tb_xform_line_streamer.sv - directed self-checking bench for xform_line_streamer
module tb_xform_line_streamer;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    logic [15:0] line_tbl [0:255];
    logic [15:0] mem_q;

    xform_line_streamer_if #(.CHAR_W(8), .ADDR_W(8), .LINE_W(8), .LEN_W(8)) bus ();

    xform_line_streamer #(.CHAR_W(8), .ADDR_W(8), .LINE_W(8), .LEN_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External table is combinational, pair memory returns {addr, ~addr} one cycle after the strobe.
    assign bus.tbl_entry = line_tbl[bus.tbl_line];
    assign bus.mem_dout  = mem_q;
    always @(posedge clk) begin
        if (bus.mem_rd) mem_q <= {bus.mem_addr, ~bus.mem_addr};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_beat(input string tag, input logic [7:0] addr,
                              input logic first, input logic last);
        logic [7:0] inv;
        inv = ~addr;
        check({tag, "_valid"}, bus.out_valid, 1);
        check({tag, "_lhs"},   bus.out_lhs,   addr);
        check({tag, "_rhs"},   bus.out_rhs,   inv);
        check({tag, "_first"}, bus.out_first, first);
        check({tag, "_last"},  bus.out_last,  last);
        check({tag, "_empty"}, bus.out_empty, 0);
    endtask

    task automatic request(input logic [7:0] line);
        bus.req_line  = line;
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] a;
        checks   = 0;
        failures = 0;
        mem_q    = 16'h0;
        for (int i = 0; i < 256; i++) line_tbl[i] = 16'h0;
        line_tbl[0] = 16'h0503;
        line_tbl[1] = 16'h0010;
        line_tbl[2] = 16'h0420;
        line_tbl[3] = 16'h03FE;
        line_tbl[4] = 16'h0540;
        line_tbl[5] = 16'h0150;
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_line  = 8'h0;
        bus.abort     = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_busy",      bus.busy,      0);
        check("rst_mem_rd",    bus.mem_rd,    0);
        check("rst_mem_addr",  bus.mem_addr,  0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_lhs",       bus.out_lhs,   0);
        rst = 1'b0;
        tick();
        bus.req_line = 8'd2;
        #1;
        check("tbl_line_comb", bus.tbl_line, 2);

        // Five-beat line, start 3, ready held high.
        request(8'd0);
        for (int i = 0; i < 5; i++) begin
            a = 8'(3 + i);
            check("t1_mem_rd",   bus.mem_rd,   1);
            check("t1_mem_addr", bus.mem_addr, a);
            check("t1_busy",     bus.busy,     1);
            tick();
            check("t1_capt_nv",  bus.out_valid, 0);
            tick();
            check_beat("t1_beat", a, i == 0, i == 4);
            tick();
        end
        check("t1_req_ready_end", bus.req_ready, 1);
        check("t1_valid_end",     bus.out_valid, 0);

        // Zero-length line.
        request(8'd1);
        check("t2_valid", bus.out_valid, 1);
        check("t2_empty", bus.out_empty, 1);
        check("t2_first", bus.out_first, 1);
        check("t2_last",  bus.out_last,  1);
        check("t2_lhs",   bus.out_lhs,   0);
        check("t2_rhs",   bus.out_rhs,   0);
        check("t2_mem_rd", bus.mem_rd,   0);
        tick();
        check("t2_idle",  bus.req_ready, 1);
        check("t2_valid_end", bus.out_valid, 0);

        // Backpressure: ready low for 4 cycles on beat 2.
        request(8'd2);
        for (int i = 0; i < 2; i++) begin
            tick();
            tick();
            check_beat("t3_beat", 8'(8'h20 + i), i == 0, 1'b0);
            tick();
        end
        bus.out_ready = 1'b0;
        tick();
        tick();
        for (int k = 0; k < 4; k++) begin
            check_beat("t3_hold", 8'h22, 1'b0, 1'b0);
            check("t3_hold_no_rd", bus.mem_rd, 0);
            if (k < 3) tick();
        end
        bus.out_ready = 1'b1;
        tick();
        check("t3_resume_rd",   bus.mem_rd,   1);
        check("t3_resume_addr", bus.mem_addr, 8'h23);
        tick();
        tick();
        check_beat("t3_beat3", 8'h23, 1'b0, 1'b1);
        tick();
        check("t3_idle", bus.req_ready, 1);

        // Address wrap FE, FF, 00.
        request(8'd3);
        for (int i = 0; i < 3; i++) begin
            a = 8'(8'hFE + i);
            check("t4_mem_addr", bus.mem_addr, a);
            tick();
            tick();
            check_beat("t4_beat", a, i == 0, i == 2);
            tick();
        end
        check("t4_idle", bus.req_ready, 1);

        // Abort together with ready on the first beat.
        request(8'd4);
        tick();
        tick();
        check_beat("t5_beat0", 8'h40, 1'b1, 1'b0);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("t5_valid",     bus.out_valid, 0);
        check("t5_req_ready", bus.req_ready, 1);
        check("t5_first",     bus.out_first, 0);
        for (int k = 0; k < 3; k++) begin
            check("t5_no_rd", bus.mem_rd, 0);
            tick();
        end

        // Abort while idle must not block an accept.
        bus.abort = 1'b1;
        request(8'd5);
        bus.abort = 1'b0;
        check("t5i_mem_rd",   bus.mem_rd,   1);
        check("t5i_mem_addr", bus.mem_addr, 8'h50);
        tick();
        tick();
        check_beat("t5i_beat", 8'h50, 1'b1, 1'b1);
        tick();
        check("t5i_idle", bus.req_ready, 1);

        // Reset during CAPT of beat 1, then a clean restart.
        request(8'd0);
        tick();
        tick();
        check_beat("t6_beat0", 8'h03, 1'b1, 1'b0);
        tick();
        tick();
        #1;
        rst = 1'b1;
        #1;
        check("t6_rst_valid",     bus.out_valid, 0);
        check("t6_rst_req_ready", bus.req_ready, 1);
        check("t6_rst_busy",      bus.busy,      0);
        check("t6_rst_mem_rd",    bus.mem_rd,    0);
        check("t6_rst_mem_addr",  bus.mem_addr,  0);
        check("t6_rst_lhs",       bus.out_lhs,   0);
        check("t6_rst_first",     bus.out_first, 0);
        tick();
        rst = 1'b0;
        tick();
        check("t6_post_valid", bus.out_valid, 0);
        check("t6_post_ready", bus.req_ready, 1);
        request(8'd0);
        tick();
        tick();
        check_beat("t6_new0", 8'h03, 1'b1, 1'b0);
        tick();
        tick();
        tick();
        check_beat("t6_new1", 8'h04, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/xform_line_streamer.md
# xform_line_streamer

Parametrised streamer for the character-transform display path. It accepts a line-number request and looks up that line's `{length, start}` entry in an external line table. It then reads the line's character pairs (lhs/rhs) from an external synchronous pair memory and emits them one pair per beat on a valid/ready stream with first/last/empty framing. It sits between the line-selection control logic and the character renderer, and supports backpressure, zero-length lines, address wrap and abort.

## Interface
Parameters:
- `CHAR_W`, 8: width of one character; memory word is 2*CHAR_W, lhs in the upper half.
- `ADDR_W`, 8: pair-memory address width.
- `LINE_W`, 8: line-number width.
- `LEN_W`, 8: line-length field width.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `req_valid`  in  1  line request valid
- `req_ready`  out  1  block idle, request can be taken
- `req_line`  in  LINE_W  requested line number
- `abort`  in  1  synchronous abandon of the current line
- `tbl_line`  out  LINE_W  line-table index, combinationally equal to `req_line`
- `tbl_entry`  in  LEN_W+ADDR_W  `{len, start}` for `tbl_line`, combinational
- `mem_rd`  out  1  pair-memory read strobe
- `mem_addr`  out  ADDR_W  pair-memory address
- `mem_dout`  in  2*CHAR_W  read data, valid the cycle after `mem_rd`
- `out_valid`  out  1  output beat valid
- `out_ready`  in  1  downstream accepts the beat
- `out_lhs`, `out_rhs`  out  CHAR_W each  untransformed / transformed character
- `out_first`, `out_last`, `out_empty`  out  1 each  beat framing
- `busy`  out  1  not IDLE

## Operation
- States: IDLE, READ, CAPT, OUT, EMPTY.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, latch `ptr`=start, `len`, and `cnt`=0.
  - If len==0, go to EMPTY; otherwise go to READ.
- READ: `mem_rd`=1 and `mem_addr`=ptr, then go to CAPT.
- CAPT: register `mem_dout` into `out_lhs`/`out_rhs`, set `out_valid`, `out_first`=(cnt==0) and `out_last`=(cnt==len-1), then go to OUT.
- OUT: hold all outputs stable until `out_valid && out_ready`. On accept:
  - if last, go to IDLE;
  - otherwise set ptr=ptr+1 (mod 2^ADDR_W, wraps FF→00 at ADDR_W=8), cnt+1, and go to READ.
- EMPTY:
  - One beat with `out_empty`=`out_first`=`out_last`=1 and lhs/rhs=0.
  - On accept, go to IDLE.
- `abort`: from any non-IDLE state, the next state is IDLE, `out_valid` clears and the flags clear. `abort` has priority over a simultaneous accept; that beat counts as not delivered. `abort` is ignored in IDLE.
- `mem_dout` is sampled only in CAPT. `mem_rd` is asserted only in READ and never while a beat is pending.
- len is treated as unsigned. The maximum is 2^LEN_W-1 beats.
- Reset values: state IDLE, `req_ready`=1, `busy`=0, `mem_rd`=0, `mem_addr`=0, `out_valid`=0, lhs/rhs=0, all flags 0.
- Reset mid-line abandons the line with no further beats.

## Timing
- The request is accepted on edge T.
  - Non-empty line: READ runs in cycle T+1, CAPT in T+2, and the first beat is visible in T+3.
  - Empty line: the beat is visible in T+1.
- With `out_ready` held high, beats arrive every 3 cycles. A line of n beats returns `req_ready` high 3n+1 cycles after T.
- `req_ready` is 0 in the cycle immediately following the final accept's state update? No: `req_ready` is high in the first cycle after the last accept, so a new request can be accepted on that edge.
- `tbl_line`/`tbl_entry` form a zero-latency combinational path and are sampled only at the accept edge.

## Structure
- Shared package `xform_pkg`:
  - state enum `xform_state_t`;
  - functions `entry_len()`/`entry_start()` that split `tbl_entry`;
  - constant `XFORM_BLANK` = 0 pair value.
- No sub-module. The line table and pair memory stay external, with the existing `memory`-style 1-cycle read.

## Test plan
- Entry {len=5, start=3}, memory data = {addr, ~addr}, `out_ready`=1: five beats at T+3, T+6 … T+15 for addresses 3..7. First is set on beat 0 only, last on beat 4 only, and `req_ready` is high at T+16.
- Entry len=0: a single beat at T+1 with empty=first=last=1 and lhs=rhs=0, then IDLE.
- `out_ready` low for 4 cycles on beat 2: lhs/rhs/flags stay stable, no `mem_rd` is issued, and the stream resumes 3 cycles after the accept.
- Entry {start=8'hFE, len=3}: reads at FE, FF, 00; last is set on the 00 beat.
- `abort` asserted in OUT together with `out_ready`: `out_valid`=0 and `req_ready`=1 on the next cycle, and no further `mem_rd`. `abort` in IDLE has no effect.
- `rst` pulsed during CAPT of beat 1: all outputs take their reset values immediately. A new request then streams from beat 0 with correct framing.
